// File: rtl/gb_pkg.sv
// rtl/gb_pkg.sv - shared LR35902 core definitions: ALU op codes, flag bits, ALU FSM states, DBUS selects
package gb_pkg;

  // misc = 0 group (prefix-10 ALU ops)
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADC  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_SBC  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_CP   = 3'b111;

  // misc = 1 group (prefix-00 column-7 ops)
  localparam logic [2:0] OP_RLCA = 3'b000;
  localparam logic [2:0] OP_RRCA = 3'b001;
  localparam logic [2:0] OP_RLA  = 3'b010;
  localparam logic [2:0] OP_RRA  = 3'b011;
  localparam logic [2:0] OP_DAA  = 3'b100;
  localparam logic [2:0] OP_CPL  = 3'b101;
  localparam logic [2:0] OP_SCF  = 3'b110;
  localparam logic [2:0] OP_CCF  = 3'b111;

  // Bit positions of the flags inside F
  localparam int FLAG_Z = 7;
  localparam int FLAG_N = 6;
  localparam int FLAG_H = 5;
  localparam int FLAG_C = 4;

  typedef enum logic [1:0] {
    ALU_IDLE = 2'b00,
    ALU_LO   = 2'b01,
    ALU_HI   = 2'b10
  } alu_state_t;

  // Register-file source mux selects
  localparam logic [1:0] DBUS_SEL_REG = 2'b00;
  localparam logic [1:0] DBUS_SEL_ALU = 2'b01;
  localparam logic [1:0] DBUS_SEL_MEM = 2'b10;
  localparam logic [1:0] DBUS_SEL_IMM = 2'b11;

  // Ops in the misc = 0 group that subtract (and therefore set N)
  function automatic logic op_is_sub(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP);
  endfunction

endpackage

// File: rtl/alu_nibble.sv
// rtl/alu_nibble.sv - combinational 4-bit adder with carry-in and carry-out
module alu_nibble (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign sum   = total[3:0];
  assign cout  = total[4];

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - two-pass nibble accumulator ALU and F register; ALU_DAA_EN enables DAA
module alu
  import gb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_begin,
  input  logic [2:0] alu_op,
  input  logic       misc,
  input  logic [7:0] alu_dest_data,
  input  logic [7:0] alu_src_data,
  input  logic       flags_wr_en,
  input  logic [7:0] flags_in,
  output logic [7:0] alu_result,
  output logic [7:0] alu_flags,
  output logic       alu_busy,
  output logic       alu_done
);

  alu_state_t state;
  logic       begin_q;
  logic [7:0] a_l;
  logic [7:0] b_l;
  logic [2:0] op_l;
  logic       misc_l;
  logic [3:0] f_l;        // F[7:4] snapshot taken at start; f_l[0] is the carry-in
  logic [3:0] flags_q;    // live F[7:4]
  logic [3:0] lo_sum;
  logic       lo_cout;

  logic       is_sub;
  logic       use_cin;
  logic       cin_l;
  logic [7:0] b_eff;
  logic       cin_lo;
  logic [3:0] nib_a;
  logic [3:0] nib_b;
  logic       nib_cin;
  logic [3:0] nib_sum;
  logic       nib_cout;
  logic [7:0] arith_res;
  logic       h_flag;
  logic       c_flag;
  logic [7:0] res_next;
  logic [3:0] f_next;
  logic       unused_flags;

  assign unused_flags = ^flags_in[3:0];

  // Subtraction is A + ~B + ~borrow, so one adder serves both directions
  assign cin_l   = f_l[0];
  assign is_sub  = !misc_l && op_is_sub(op_l);
  assign use_cin = !misc_l && ((op_l == OP_ADC) || (op_l == OP_SBC));
  assign b_eff   = is_sub ? ~b_l : b_l;
  assign cin_lo  = is_sub ? ~(use_cin & cin_l) : (use_cin & cin_l);

  // The single nibble adder takes the low half in LO and the high half in HI
  assign nib_a   = (state == ALU_HI) ? a_l[7:4]   : a_l[3:0];
  assign nib_b   = (state == ALU_HI) ? b_eff[7:4] : b_eff[3:0];
  assign nib_cin = (state == ALU_HI) ? lo_cout    : cin_lo;

  alu_nibble u_nibble (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (nib_cin),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // A carry out of the adder means "no borrow" when subtracting
  assign arith_res = {nib_sum, lo_sum};
  assign h_flag    = is_sub ? ~lo_cout  : lo_cout;
  assign c_flag    = is_sub ? ~nib_cout : nib_cout;

`ifdef ALU_DAA_EN
  logic [7:0] daa_adj;
  logic [7:0] daa_res;
  logic       daa_c;

  // Decimal adjust uses N/H/C as they stood when the op started
  always_comb begin
    daa_adj = 8'h00;
    daa_c   = f_l[0];
    if (!f_l[2]) begin
      if (f_l[0] || (a_l > 8'h99)) begin
        daa_adj[7:4] = 4'h6;
        daa_c        = 1'b1;
      end
      if (f_l[1] || (a_l[3:0] > 4'h9)) begin
        daa_adj[3:0] = 4'h6;
      end
      daa_res = a_l + daa_adj;
    end else begin
      if (f_l[0]) begin
        daa_adj[7:4] = 4'h6;
      end
      if (f_l[1]) begin
        daa_adj[3:0] = 4'h6;
      end
      daa_res = a_l - daa_adj;
    end
  end
`endif

  // Result and flags committed at the end of the HI pass
  always_comb begin
    res_next = a_l;
    f_next   = flags_q;
    if (!misc_l) begin
      case (op_l)
        OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
          res_next = arith_res;
          f_next   = {arith_res == 8'h00, is_sub, h_flag, c_flag};
        end
        OP_CP: begin
          res_next = a_l;
          f_next   = {arith_res == 8'h00, 1'b1, h_flag, c_flag};
        end
        OP_AND: begin
          res_next = a_l & b_l;
          f_next   = {(a_l & b_l) == 8'h00, 1'b0, 1'b1, 1'b0};
        end
        OP_XOR: begin
          res_next = a_l ^ b_l;
          f_next   = {(a_l ^ b_l) == 8'h00, 1'b0, 1'b0, 1'b0};
        end
        default: begin
          res_next = a_l | b_l;
          f_next   = {(a_l | b_l) == 8'h00, 1'b0, 1'b0, 1'b0};
        end
      endcase
    end else begin
      case (op_l)
        OP_RLCA: begin
          res_next = {a_l[6:0], a_l[7]};
          f_next   = {3'b000, a_l[7]};
        end
        OP_RRCA: begin
          res_next = {a_l[0], a_l[7:1]};
          f_next   = {3'b000, a_l[0]};
        end
        OP_RLA: begin
          res_next = {a_l[6:0], cin_l};
          f_next   = {3'b000, a_l[7]};
        end
        OP_RRA: begin
          res_next = {cin_l, a_l[7:1]};
          f_next   = {3'b000, a_l[0]};
        end
        OP_DAA: begin
`ifdef ALU_DAA_EN
          res_next = daa_res;
          f_next   = {daa_res == 8'h00, f_l[2], 1'b0, daa_c};
`else
          res_next = a_l;
          f_next   = flags_q;
`endif
        end
        OP_CPL: begin
          res_next = ~a_l;
          f_next   = {flags_q[3], 1'b1, 1'b1, flags_q[0]};
        end
        OP_SCF: begin
          res_next = a_l;
          f_next   = {flags_q[3], 1'b0, 1'b0, 1'b1};
        end
        default: begin
          res_next = a_l;
          f_next   = {flags_q[3], 1'b0, 1'b0, ~cin_l};
        end
      endcase
    end
  end

  // Sequencer IDLE -> LO -> HI -> IDLE with edge-detected start and F ownership
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ALU_IDLE;
      begin_q    <= 1'b0;
      a_l        <= 8'h00;
      b_l        <= 8'h00;
      op_l       <= 3'b000;
      misc_l     <= 1'b0;
      f_l        <= 4'h0;
      flags_q    <= 4'h0;
      lo_sum     <= 4'h0;
      lo_cout    <= 1'b0;
      alu_result <= 8'h00;
      alu_done   <= 1'b0;
    end else begin
      begin_q  <= alu_begin;
      alu_done <= 1'b0;
      if (flags_wr_en && (state != ALU_HI)) begin
        flags_q <= flags_in[7:4];
      end
      case (state)
        ALU_IDLE: begin
          if (alu_begin && !begin_q) begin
            a_l    <= alu_dest_data;
            b_l    <= alu_src_data;
            op_l   <= alu_op;
            misc_l <= misc;
            f_l    <= flags_q;
            state  <= ALU_LO;
          end
        end
        ALU_LO: begin
          lo_sum  <= nib_sum;
          lo_cout <= nib_cout;
          state   <= ALU_HI;
        end
        ALU_HI: begin
          alu_result <= res_next;
          flags_q    <= f_next;
          alu_done   <= 1'b1;
          state      <= ALU_IDLE;
        end
        default: state <= ALU_IDLE;
      endcase
    end
  end

  assign alu_flags = {flags_q, 4'b0000};
  assign alu_busy  = (state != ALU_IDLE);

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - scoreboard bench for alu with directed vectors
module tb_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       alu_begin;
  logic [2:0] alu_op;
  logic       misc;
  logic [7:0] alu_dest_data;
  logic [7:0] alu_src_data;
  logic       flags_wr_en;
  logic [7:0] flags_in;
  logic [7:0] alu_result;
  logic [7:0] alu_flags;
  logic       alu_busy;
  logic       alu_done;

  typedef struct {
    logic [7:0] res;
    logic [7:0] f;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   total    = 0;
  int   bad      = 0;
  int   done_cnt = 0;
  int   pushed   = 0;

  always #5 clk = ~clk;

  alu dut (
    .clk           (clk),
    .rst           (rst),
    .alu_begin     (alu_begin),
    .alu_op        (alu_op),
    .misc          (misc),
    .alu_dest_data (alu_dest_data),
    .alu_src_data  (alu_src_data),
    .flags_wr_en   (flags_wr_en),
    .flags_in      (flags_in),
    .alu_result    (alu_result),
    .alu_flags     (alu_flags),
    .alu_busy      (alu_busy),
    .alu_done      (alu_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every alu_done pops one expectation
  always @(negedge clk) begin
    if (alu_done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        check("spurious_done", {31'b0, alu_done}, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, {24'b0, alu_result}, {24'b0, e.res});
        check({e.name, "_flags"}, {24'b0, alu_flags}, {24'b0, e.f});
      end
    end
  end

  // wr_n: negedge index after start at which flags_wr_en is pulsed (0 = none)
  task automatic do_op(input string name, input logic m, input logic [2:0] op,
                       input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] er, input logic [7:0] ef,
                       input int wr_n, input logic [7:0] fv);
    int n;
    @(negedge clk);
    misc          = m;
    alu_op        = op;
    alu_dest_data = av;
    alu_src_data  = bv;
    alu_begin     = 1'b1;
    sb.push_back('{er, ef, name});
    pushed++;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      flags_wr_en = 1'b0;
      if (n == 1) begin
        alu_dest_data = ~av;
        alu_src_data  = ~bv;
        alu_op        = ~op;
        misc          = ~m;
      end
      if (n == wr_n) begin
        flags_wr_en = 1'b1;
        flags_in    = fv;
      end
    end while (!alu_done && n < 6);
    check({name, "_latency"}, n, 3);
    alu_begin = 1'b0;
  endtask

  task automatic idle_write(input logic [7:0] fv, input logic [7:0] ef);
    @(negedge clk);
    flags_wr_en = 1'b1;
    flags_in    = fv;
    @(negedge clk);
    flags_wr_en = 1'b0;
    check("idle_flag_write", {24'b0, alu_flags}, {24'b0, ef});
  endtask

  initial begin
    int base;
    rst           = 1'b0;
    alu_begin     = 1'b0;
    alu_op        = 3'b000;
    misc          = 1'b0;
    alu_dest_data = 8'h00;
    alu_src_data  = 8'h00;
    flags_wr_en   = 1'b0;
    flags_in      = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_result", {24'b0, alu_result}, 32'h00);
    check("rst_flags", {24'b0, alu_flags}, 32'h00);
    check("rst_busy", {31'b0, alu_busy}, 32'd0);
    check("rst_done", {31'b0, alu_done}, 32'd0);
    rst = 1'b1;

    do_op("add_zhc",  1'b0, 3'b000, 8'h3A, 8'hC6, 8'h00, 8'hB0, 0, 8'h00);
    do_op("sbc",      1'b0, 3'b011, 8'h10, 8'h01, 8'h0E, 8'h60, 0, 8'h00);
    do_op("cp_eq",    1'b0, 3'b111, 8'h42, 8'h42, 8'h42, 8'hC0, 0, 8'h00);
    do_op("rla",      1'b1, 3'b010, 8'h80, 8'h00, 8'h00, 8'h10, 0, 8'h00);
    do_op("add_bcd",  1'b0, 3'b000, 8'h45, 8'h38, 8'h7D, 8'h00, 0, 8'h00);
`ifdef ALU_DAA_EN
    do_op("daa",      1'b1, 3'b100, 8'h7D, 8'h00, 8'h83, 8'h00, 0, 8'h00);
`else
    do_op("daa_nop",  1'b1, 3'b100, 8'h7D, 8'h00, 8'h7D, 8'h00, 0, 8'h00);
`endif
    do_op("xor",      1'b0, 3'b101, 8'h5A, 8'h5A, 8'h00, 8'h80, 0, 8'h00);
    do_op("and",      1'b0, 3'b100, 8'hF0, 8'h0F, 8'h00, 8'hA0, 0, 8'h00);
    do_op("or",       1'b0, 3'b110, 8'h12, 8'h40, 8'h52, 8'h00, 0, 8'h00);
    do_op("sub_wrap", 1'b0, 3'b010, 8'h00, 8'h01, 8'hFF, 8'h70, 0, 8'h00);
    do_op("cpl",      1'b1, 3'b101, 8'h35, 8'h00, 8'hCA, 8'h70, 0, 8'h00);
    do_op("scf",      1'b1, 3'b110, 8'h11, 8'h00, 8'h11, 8'h10, 0, 8'h00);
    do_op("ccf",      1'b1, 3'b111, 8'h11, 8'h00, 8'h11, 8'h00, 0, 8'h00);
    do_op("rrca",     1'b1, 3'b001, 8'h01, 8'h00, 8'h80, 8'h10, 0, 8'h00);
    do_op("rra",      1'b1, 3'b011, 8'h02, 8'h00, 8'h81, 8'h00, 0, 8'h00);
    do_op("rlca",     1'b1, 3'b000, 8'h81, 8'h00, 8'h03, 8'h10, 0, 8'h00);
    do_op("adc_h",    1'b0, 3'b001, 8'h0F, 8'h00, 8'h10, 8'h20, 0, 8'h00);

    idle_write(8'hF5, 8'hF0);
    do_op("cpl_keepz", 1'b1, 3'b101, 8'h00, 8'h00, 8'hFF, 8'hF0, 0, 8'h00);

    idle_write(8'h00, 8'h00);
    do_op("adc_lo_wr", 1'b0, 3'b001, 8'h00, 8'h00, 8'h00, 8'h80, 1, 8'h10);
    do_op("add_hi_wr", 1'b0, 3'b000, 8'h01, 8'h01, 8'h02, 8'h00, 2, 8'hF0);
    @(negedge clk);
    check("hi_write_dropped", {24'b0, alu_flags}, 32'h00);

    // Level held for six cycles must produce exactly one operation
    base = done_cnt;
    @(negedge clk);
    misc          = 1'b0;
    alu_op        = 3'b000;
    alu_dest_data = 8'h01;
    alu_src_data  = 8'h02;
    alu_begin     = 1'b1;
    sb.push_back('{8'h03, 8'h00, "hold"});
    pushed++;
    repeat (6) @(negedge clk);
    alu_begin = 1'b0;
    repeat (4) @(negedge clk);
    check("hold_single_done", done_cnt - base, 1);

    // Reset during LO aborts the operation
    @(negedge clk);
    alu_dest_data = 8'hFF;
    alu_src_data  = 8'h01;
    alu_begin     = 1'b1;
    @(negedge clk);
    check("abort_busy_lo", {31'b0, alu_busy}, 32'd1);
    rst       = 1'b0;
    alu_begin = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'b0, alu_busy}, 32'd0);
    check("abort_result", {24'b0, alu_result}, 32'h00);
    check("abort_flags", {24'b0, alu_flags}, 32'h00);
    check("abort_done", {31'b0, alu_done}, 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    do_op("after_rst", 1'b0, 3'b000, 8'h01, 8'h02, 8'h03, 8'h00, 0, 8'h00);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("done_count", done_cnt, pushed);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Sequential 8-bit accumulator ALU and flag register (F) for the LR35902 core, directly downstream of `decode`. Consumes `alu_begin`, `alu_op`, `misc`, `alu_src_data` and `alu_dest_data`, and produces the result that the register-file source mux selects as ALU (`reg_src_sel = 2'b01`). Arithmetic is performed as two 4-bit nibble passes (low, then high), matching the original part's nibble ALU, which gives half-carry for free. Owns the Z/N/H/C flags.

## Interface
Parameters:
- none (op encodings live in the shared package)

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  reset; synchronous, active-low
- `alu_begin`  in  1  start request from decode; level, edge-detected internally
- `alu_op`  in  3  operation select
- `misc`  in  1  0 = prefix-10 ALU group, 1 = prefix-00 column-7 group
- `alu_dest_data`  in  8  accumulator operand (A)
- `alu_src_data`  in  8  second operand (register or immediate)
- `flags_wr_en`  in  1  external F load (POP AF)
- `flags_in`  in  8  external F value; only [7:4] are used
- `alu_result`  out  8  result register
- `alu_flags`  out  8  {Z,N,H,C,4'b0}
- `alu_busy`  out  1  high while the state is LO or HI
- `alu_done`  out  1  one-cycle pulse when the result and flags are committed

## Operation
- Group `misc=0`: 000 ADD, 001 ADC, 010 SUB, 011 SBC, 100 AND, 101 XOR, 110 OR, 111 CP.
- Group `misc=1`: 000 RLCA, 001 RRCA, 010 RLA, 011 RRA, 100 DAA, 101 CPL, 110 SCF, 111 CCF.
- FSM states:
  - IDLE: a rising edge of `alu_begin` moves to LO and latches the operands, the op, `misc`, and carry-in = F.C.
  - LO → HI: computes low nibble and H (carry out of bit 3, or borrow into bit 3 for subtracts).
  - HI → IDLE: computes high nibble and C (carry/borrow at bit 7); commits `alu_result` and F; pulses `alu_done`.
- Arithmetic: ADC/SBC use the carry-in latched at start. SUB/SBC/CP set N=1; ADD/ADC set N=0. Z = (result == 0).
- Logic ops: AND sets H=1; XOR and OR set H=0. All three set N=0 and C=0.
- CP: flags as SUB, but `alu_result` = A, so decode's A writeback is harmless.
- Rotates operate on A; Z=N=H=0.
  - RLCA: C=A7, result {A[6:0],A7}.
  - RLA: result {A[6:0],oldC}, C=A7.
  - RRCA and RRA mirror these.
- CPL: result ~A, N=H=1. SCF: C=1. CCF: C=~C. For SCF and CCF, N=H=0 and result = A. CPL, SCF and CCF leave Z unchanged.
- The `misc`-group ops still take the LO and HI cycles, so latency is uniform.

## Timing
- Reset values: `alu_result`=0, `alu_flags`=0, `alu_busy`=0, `alu_done`=0, state IDLE, edge-detect register 0.
- Latency: begin edge sampled at clock edge k → `alu_done` and new result/flags visible after edge k+2.
- `alu_begin` high while busy: ignored; a new start needs a low-then-high transition seen in IDLE.
- `alu_begin` held high across `alu_done`: no restart.
- `flags_wr_en`:
  - In IDLE or LO it loads F[7:4] immediately.
  - Coincident with HI commit, the ALU commit wins and the external write is dropped.
  - A write during LO does not change the latched carry-in.
- Operands are latched at start; input changes in LO/HI have no effect.
- Reset mid-operation: returns to IDLE next edge, no `alu_done`, all outputs to reset values.

## Configuration
- `ALU_DAA_EN` defined: DAA adjusts A per N/H/C using the standard LR35902 rules; Z recomputed, H=0, N kept, C set if the adjust exceeds 0x99 (or C was already set).
- Not defined: DAA behaves as a NOP; result = A, F unchanged, same two-cycle latency.

## Structure
- Shared package `gb_pkg`: ALU op localparams (both groups), flag bit indices (Z=7, N=6, H=5, C=4), ALU FSM state encoding, DBUS mux select codes.
- One sub-module, `alu_nibble`: combinational 4-bit add/subtract with carry-in, returning a 4-bit sum and carry-out. It is instantiated once and reused across the LO and HI passes.

## Test plan
- ADD A=0x3A, B=0xC6 → result 0x00, F=0xB0 (Z,H,C); `alu_done` exactly 2 cycles after the begin edge.
- SBC A=0x10, B=0x01 with C=1 → result 0x0E, F=0x60 (N,H).
- CP A=0x42, B=0x42 → result 0x42, F=0xC0; then RLA with A=0x80, C=0 → result 0x00, F=0x10.
- With `ALU_DAA_EN`: ADD 0x45+0x38 = 0x7D, then DAA → 0x83, F=0x00. Without the macro: DAA → 0x7D, F unchanged.
- Hold `alu_begin` high for 6 cycles → exactly one `alu_done`. Assert `flags_wr_en` (`flags_in`=0xF0) in the HI cycle → ALU flags win.
- Assert `rst`=0 during LO → next cycle IDLE, outputs zero, no `alu_done`; a subsequent begin edge works normally.
